p6502_bus_sequencer: RTL and testbench
======================================

// Module: p6502_bus_sequencer
// PURPOSE
//  Parametrised 6502-style bus master. Replays queued read/write commands as phi0-timed bus cycles.
//  Generates its own phi0/phi2 from clk and honours RDY wait states with a timeout.
//  Returns read data on a response strobe.
//  Sits in place of the CPU core: drives video/sound RAM and register decoders for bring-up and scripted init.
// PARAMETERS
//  ADDR_W    16  address bus width
//  DATA_W     8  data bus width
//  DEPTH      4  command FIFO entries, power of 2, >=2
//  HALF       2  clk cycles per phi0 half-period, >=1
//  MAX_WAIT  15  max RDY-stretched repeats of one read before abort, 1..255
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       FIFO not full; a command transfers when valid&ready
//  cmd_we     in   1       1=write, 0=read
//  cmd_addr   in   ADDR_W  bus address
//  cmd_wdata  in   DATA_W  write data, ignored for reads
//  rsp_valid  out  1       one-clk read-completion strobe
//  rsp_data   out  DATA_W  read data, valid with rsp_valid
//  rsp_err    out  1       read aborted by RDY timeout, valid with rsp_valid
//  busy       out  1       1 while FIFO non-empty or a command is in flight
//  phi0       out  1       bus clock
//  phi2       out  1       ~phi0
//  rw_n       out  1       bus read/write_n
//  a          out  ADDR_W  bus address
//  dout       out  DATA_W  bus write data
//  din        in   DATA_W  bus read data
//  rdy        in   1       1=ready; 0 stretches read cycles only
// BEHAVIOUR
//  Reset values:
//   - phi0=0, phi2=1, rw_n=1, a=0, dout=0
//   - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0
//   - FIFO empty, so cmd_ready=1; phase counter 0; wait counter 0; no command in flight.
//  Clocking:
//   - phi0 free-runs from the clk after reset release: low for HALF clks (PHI1), then high for HALF clks (PHI2).
//   - phi0 also runs while idle.
//   - Cycle boundary = final clk of PHI2.
//  Issue:
//   - At each boundary, if no command is in flight or repeating, pop the FIFO head.
//   - The popped command owns the next bus cycle; a, dout and the command type are registered at the boundary.
//   - FIFO empty at a boundary: idle cycle. a and dout hold, rw_n=1.
//   - Back-to-back commands issue in consecutive bus cycles with no idle gap.
//  Write cycle:
//   - a and dout stable for the whole cycle.
//   - rw_n=0 only during PHI2, and 1 during PHI1.
//   - RDY is ignored. No response is generated.
//  Read cycle:
//   - rw_n=1. din and rdy are sampled on the boundary clk.
//   - rdy=1: rsp_valid=1 for exactly the next clk, rsp_data=sampled din, rsp_err=0.
//   - rdy=0 and wait_cnt<MAX_WAIT: repeat the same cycle with unchanged a, and increment wait_cnt. No pop.
//   - rdy=0 and wait_cnt==MAX_WAIT: abort. rsp_valid=1, rsp_err=1, rsp_data=0.
//   - wait_cnt clears on every pop.
//  FIFO:
//   - Registered storage with pointers wrapping at DEPTH and an occupancy count 0..DEPTH.
//   - cmd_ready = (count!=DEPTH). There is no bypass.
//   - A push and a pop in the same clk leave count unchanged.
//   - When full, the slot freed by a pop accepts a push from the following clk.
//  busy = (count!=0) | in_flight.
//  Reset asserted mid-cycle:
//   - The next clk shows the reset values.
//   - The in-flight command is dropped with no response; queued commands are discarded.
//  Latency: a command pushed into an idle, empty block appears on a at the next boundary +1 clk.
// TESTING (HALF=2, DEPTH=4, MAX_WAIT=15)
//  1 Reset release -> phi0 0,0,1,1 repeating; rw_n=1, a=0, cmd_ready=1, busy=0 throughout idle.
//  2 Write 0x0501<-0x01 -> a=0x0501, dout=0x01 for 4 clks; rw_n=0 only on the 2 phi0-high clks; no rsp_valid.
//  3 Read 0x07C0, din=0x5A, rdy=1 -> one rsp_valid pulse with rsp_data=0x5A and rsp_err=0, 1 clk after the boundary.
//  4 Read with rdy=0 at 3 boundaries, then 1 -> a held for 4 periods, one response. rdy held 0 -> rsp_err=1 after 16 periods.
//  5 Push 6 writes back-to-back while busy -> cmd_ready drops at 4 queued; all 6 appear in order in consecutive cycles.
//  6 Reset during PHI2 of a write -> rw_n=1 and busy=0 next clk; later reads respond normally.

Source files
------------

// File: rtl/p6502_bus_sequencer.sv
// ---------------------------------------------------------------------------
// p6502_bus_sequencer
//
// 6502-style bus master that stands in for the CPU core during bring-up and
// scripted initialisation. Read/write commands are queued in a small FIFO and
// replayed one per phi0 bus cycle. The block generates its own phi0/phi2 from
// clk. Read cycles are stretched by RDY wait states, and a read is aborted
// once it has been repeated MAX_WAIT times. Read results come back on a
// one-clk response strobe.
//
// Parameters
//   ADDR_W    bus address width
//   DATA_W    bus data width
//   DEPTH     command FIFO entries (power of 2, >= 2)
//   HALF      clk cycles per phi0 half-period (>= 1)
//   MAX_WAIT  RDY-stretched repeats of one read before abort (1..255)
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; transfer on valid & ready
//   cmd_we                1 = write, 0 = read
//   cmd_addr, cmd_wdata   command address and write data
//   rsp_valid             one-clk read completion strobe
//   rsp_data, rsp_err     read data / RDY-timeout abort flag, valid with rsp_valid
//   busy                  FIFO non-empty or a command in flight
//   phi0, phi2            bus clocks (phi2 = ~phi0)
//   rw_n, a, dout         bus read/write_n, address, write data
//   din, rdy              bus read data, ready (0 stretches reads only)
// ---------------------------------------------------------------------------
module p6502_bus_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int HALF     = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              phi0,
    output logic              phi2,
    output logic              rw_n,
    output logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] din,
    input  logic              rdy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PH_W   = $clog2(2 * HALF);
    localparam int WAIT_W = 8;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PH_W-1:0]   PH_HALF  = PH_W'(HALF);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * HALF - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    // Command FIFO storage (data only, never reset)
    logic              fifo_we    [DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata [DEPTH];

    // Control state
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [PH_W-1:0]   ph_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_flight;
    logic              cur_we;

    // Combinational decode
    logic              ph_last;
    logic [PH_W-1:0]   ph_next;
    logic              phi0_next;
    logic              push;
    logic              pop;
    logic              cur_is_read;
    logic              rd_stall;
    logic              rd_repeat;
    logic              rd_abort;
    logic              rd_ok;
    logic              next_in_flight;
    logic              next_we;

    // Phase counter step: wraps after the final clk of PHI2.
    function automatic logic [PH_W-1:0] ph_step(input logic [PH_W-1:0] ph);
        return (ph == PH_LAST) ? '0 : ph + 1'b1;
    endfunction

    assign cmd_ready = (count != CNT_FULL);
    assign busy      = (count != '0) | in_flight;
    assign phi2      = ~phi0;

    always_comb begin
        ph_last     = (ph_cnt == PH_LAST);
        ph_next     = ph_step(ph_cnt);
        phi0_next   = (ph_next >= PH_HALF);
        push        = cmd_valid & cmd_ready;
        cur_is_read = in_flight & ~cur_we;

        // Read completion is decided on the boundary clk only.
        rd_stall  = ph_last & cur_is_read & ~rdy;
        rd_repeat = rd_stall & (wait_cnt < WAIT_MAX);
        rd_abort  = rd_stall & ~rd_repeat;
        rd_ok     = ph_last & cur_is_read & rdy;

        // A repeating read keeps the bus; otherwise the FIFO head is taken.
        pop = ph_last & ~rd_repeat & (count != '0);

        next_in_flight = in_flight;
        next_we        = cur_we;
        if (ph_last) begin
            next_in_flight = rd_repeat | (count != '0);
            if (pop) begin
                next_we = fifo_we[rd_ptr];
            end
        end
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]    <= cmd_we;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
        end
    end

    // Bus sequencing, FIFO pointers and response strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            ph_cnt    <= '0;
            phi0      <= 1'b0;
            rw_n      <= 1'b1;
            a         <= '0;
            dout      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wait_cnt  <= '0;
            in_flight <= 1'b0;
            cur_we    <= 1'b0;
        end else begin
            ph_cnt <= ph_next;
            phi0   <= phi0_next;
            // rw_n is only pulled low during PHI2 of an owned write cycle.
            rw_n   <= ~(next_in_flight & next_we & phi0_next);

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            rsp_valid <= rd_ok | rd_abort;
            if (rd_ok) begin
                rsp_data <= din;
                rsp_err  <= 1'b0;
            end else if (rd_abort) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end

            // Boundary: retire the current cycle and register the next one.
            if (ph_last) begin
                in_flight <= next_in_flight;
                cur_we    <= next_we;
                wait_cnt  <= rd_repeat ? wait_cnt + 1'b1 : '0;
                if (pop) begin
                    a    <= fifo_addr[rd_ptr];
                    dout <= fifo_wdata[rd_ptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_p6502_bus_sequencer.sv
module tb_p6502_bus_sequencer;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int HALF     = 2;
  localparam int MAX_WAIT = 15;
  localparam int PERIOD   = 2 * HALF;
  localparam int NT       = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              phi0;
  logic              phi2;
  logic              rw_n;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] din = '0;
  logic              rdy = 1'b1;

  p6502_bus_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .HALF(HALF), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .phi0(phi0), .phi2(phi2), .rw_n(rw_n),
    .a(a), .dout(dout), .din(din), .rdy(rdy)
  );

  always #5 clk = ~clk;

  // Slave address map: read data and the number of RDY=0 boundaries it inserts.
  logic [ADDR_W-1:0] t_addr  [NT] = '{16'h0501, 16'h07C0, 16'h1234, 16'h2000,
                                      16'h3FFF, 16'hFFFF, 16'h0100, 16'hABCD};
  logic [DATA_W-1:0] t_data  [NT] = '{8'h33, 8'h5A, 8'h11, 8'hEE, 8'h77, 8'h80, 8'h01, 8'hC3};
  int                t_stall [NT] = '{0, 0, 3, 15, 16, 1, 0, 2};

  typedef struct packed { logic [ADDR_W-1:0] ad; logic [DATA_W-1:0] d; } wr_t;
  typedef struct packed { logic [DATA_W-1:0] d; logic e; } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  int  wr_pers[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference phase/period counters, restarted by reset like the bus clock.
  int ph_m  = 0;
  int per_m = 0;
  always @(posedge clk) begin
    if (reset) begin
      ph_m <= 0;
    end else begin
      ph_m <= (ph_m + 1) % PERIOD;
      if (ph_m == PERIOD - 1) per_m <= per_m + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int find_idx(input logic [ADDR_W-1:0] ad);
    for (int i = 0; i < NT; i++) if (t_addr[i] == ad) return i;
    return -1;
  endfunction

  // A read succeeds once its stalls fit in MAX_WAIT repeats, else it aborts.
  function automatic rd_t ref_read(input logic [ADDR_W-1:0] ad);
    rd_t r;
    int  i;
    i = find_idx(ad);
    if (t_stall[i] > MAX_WAIT) begin
      r.d = '0; r.e = 1'b1;
    end else begin
      r.d = t_data[i]; r.e = 1'b0;
    end
    return r;
  endfunction

  // Bus slave: counts boundaries spent on the same address since the last
  // response and holds RDY low for the mapped number of boundaries.
  int                s_cnt = 0;
  logic [ADDR_W-1:0] a_bnd = '0;
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (ph_m == 0) begin
        if (rsp_valid || a != a_bnd) s_cnt = 0;
        else s_cnt++;
      end
      if (ph_m == PERIOD - 1) begin
        a_bnd = a;
        idx = find_idx(a);
        if (idx >= 0) begin
          rdy = (s_cnt >= t_stall[idx]);
          din = t_data[idx];
        end else begin
          rdy = 1'($urandom_range(0, 1));
          din = 8'($urandom);
        end
      end
    end
  end

  // Monitor: bus clock shape, write cycles and read responses.
  wr_t               cur_w;
  logic [ADDR_W-1:0] a_ph0 = '0;
  logic [DATA_W-1:0] dout_ph0 = '0;
  logic              w_act = 1'b0;
  initial begin
    rd_t r;
    forever begin
      @(negedge clk);
      chk("phi0", phi0, (ph_m >= HALF));
      chk("phi2", phi2, (ph_m < HALF));
      if (ph_m < HALF) chk("rw_n_phi1", rw_n, 1);
      if (ph_m == 0) begin
        a_ph0 = a; dout_ph0 = dout; w_act = 1'b0;
      end
      if (ph_m == HALF && rw_n == 1'b0) begin
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: a=0x%0h dout=0x%0h, none queued", a, dout);
        end else begin
          cur_w = wq.pop_front();
          w_act = 1'b1;
          wr_pers.push_back(per_m);
          chk("write_a", a, cur_w.ad);
          chk("write_dout", dout, cur_w.d);
          chk("write_a_phi1", a_ph0, cur_w.ad);
          chk("write_dout_phi1", dout_ph0, cur_w.d);
        end
      end
      if (ph_m == PERIOD - 1 && w_act) begin
        chk("write_rw_n_end", rw_n, 0);
        chk("write_a_end", a, cur_w.ad);
        chk("write_dout_end", dout, cur_w.d);
      end
      if (rsp_valid) begin
        chk("rsp_phase", ph_m, 0);
        if (rq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: data=0x%0h err=%0d, none queued", rsp_data, rsp_err);
        end else begin
          r = rq.pop_front();
          chk("rsp_data", rsp_data, r.d);
          chk("rsp_err", rsp_err, r.e);
        end
      end
    end
  end

  // Offer one command (caller is at a negedge); returns one clk after transfer.
  task automatic push_cmd(input logic we, input logic [ADDR_W-1:0] ad,
                          input logic [DATA_W-1:0] wd, output logic stalled);
    int guard = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = ad; cmd_wdata = wd;
    stalled = 1'b0;
    while (cmd_ready !== 1'b1 && guard < 2000) begin
      stalled = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_chk++;
      $display("FAIL push_timeout: cmd_ready=%0b required 1", cmd_ready);
    end else if (we) begin
      wq.push_back('{ad: ad, d: wd});
    end else begin
      rq.push_back(ref_read(ad));
    end
    @(negedge clk);
  endtask

  // Wait for an idle block at the start of a bus cycle.
  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && ph_m == 0) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4000) begin
      n_chk++;
      $display("FAIL idle_timeout: busy=%0b required 0", busy);
    end
  endtask

  // Read into an idle block; latency from push to response strobe in clks.
  task automatic read_latency(input int idx);
    int   n;
    int   s;
    logic st;
    wait_idle();
    push_cmd(1'b0, t_addr[idx], 8'h00, st);
    cmd_valid = 1'b0;
    chk("busy_after_push", busy, 1);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    s = (t_stall[idx] > MAX_WAIT) ? MAX_WAIT : t_stall[idx];
    chk("read_latency", n, PERIOD * (s + 2));
  endtask

  initial begin
    logic st;
    logic saw_drop;
    int   prev;
    int   idx;
    int   gap;

    // Reset and idle bus
    repeat (3) @(negedge clk);
    chk("reset_rw_n", rw_n, 1);
    chk("reset_a", a, 0);
    chk("reset_dout", dout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_err", rsp_err, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_rw_n", rw_n, 1);
      chk("idle_a", a, 0);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
    end

    // Single write, then single reads of varying stall depth
    wait_idle();
    push_cmd(1'b1, 16'h0501, 8'h01, st);
    cmd_valid = 1'b0;
    chk("busy_write", busy, 1);
    read_latency(1);
    read_latency(2);
    read_latency(3);
    read_latency(4);
    read_latency(5);

    // Burst of six writes: FIFO fills, cycles stay back-to-back
    wait_idle();
    wr_pers.delete();
    saw_drop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push_cmd(1'b1, t_addr[k], 8'h10 + 8'(k), st);
      saw_drop = saw_drop | st;
    end
    cmd_valid = 1'b0;
    wait_idle();
    chk("burst_ready_drop", saw_drop, 1);
    chk("burst_writes", wr_pers.size(), 6);
    for (int k = 1; k < 6 && k < wr_pers.size(); k++)
      chk("burst_gap", wr_pers[k] - wr_pers[k-1], 1);

    // Reset during PHI2 of a write
    wait_idle();
    push_cmd(1'b1, 16'h2000, 8'h99, st);
    cmd_valid = 1'b0;
    begin
      int guard = 0;
      while (!(ph_m == HALF && rw_n == 1'b0) && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk("reset_test_write_seen", rw_n, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_rw_n", rw_n, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_a", a, 0);
    chk("midreset_dout", dout, 0);
    chk("midreset_ready", cmd_ready, 1);
    chk("midreset_phi0", phi0, 0);
    reset = 1'b0;
    read_latency(1);
    read_latency(7);

    // Randomised command stream against the slave map
    prev = -1;
    for (int n = 0; n < 60; n++) begin
      gap = $urandom_range(0, 5);
      if (gap > 0) begin
        cmd_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      do idx = $urandom_range(0, NT - 1); while (idx == prev);
      prev = idx;
      push_cmd(1'($urandom_range(0, 1)), t_addr[idx], 8'($urandom), st);
    end
    cmd_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("writes_drained", wq.size(), 0);
    chk("reads_drained", rq.size(), 0);
    chk("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
